// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and by the matching receiver.
package uart_pkg;

    // Payload width of one UART character.
    localparam int UART_DATA_BITS = 8;

    // Default bit period in clock cycles, shared by the TX/RX pair.
    localparam int UART_CLK_PER_BIT_DEFAULT = 4;

    // Transmit frame states. S_PARITY is only reachable when parity is built in.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLK_PER_BIT-1 while enabled and flags the last
// cycle of each serial bit with a one-cycle o_bit_end pulse.
module uart_bit_timer #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_bit_end
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap explicitly at LAST so non-power-of-2 periods never run past the bit.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign o_bit_end = i_en && !i_clr && (cnt_q == LAST);

    // Counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 / 8N2 UART transmitter, LSB first, with a one-byte holding register.
// Optional parity bit after data bit 7 when UART_TX_PARITY_EN is defined
// (sense chosen by PARITY_ODD); without the macro no parity logic exists.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEFAULT,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [UART_DATA_BITS-1:0] i_data,
    input  logic                      i_data_valid,
    output logic                      o_data_ready,
    output logic                      o_tx,
    output logic                      o_busy
);

    localparam logic [2:0] LAST_DATA_IDX = 3'(UART_DATA_BITS - 1);
    localparam logic       LAST_STOP_IDX = 1'(STOP_BITS - 1);

    // Reject parameter values the frame logic cannot represent.
    generate
        if (CLK_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
            (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
            $error("uart_tx: illegal CLK_PER_BIT, STOP_BITS or PARITY_ODD");
        end
    endgenerate

    uart_state_e               state_q, state_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      stop_idx_q, stop_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic                      hold_full_q, hold_full_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    logic bit_end;
    logic load;
    logic accept;

    uart_bit_timer #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (state_q != S_IDLE),
        .i_clr    (state_q == S_IDLE),
        .o_bit_end(bit_end)
    );

    // Holding register only accepts when empty; a byte loads into the
    // shifter only from the registered full flag, so accept and load
    // never happen on the same edge.
    assign accept       = i_data_valid && !hold_full_q;
    assign o_data_ready = !hold_full_q;
    assign o_tx         = tx_q;
    assign o_busy       = busy_q;

    // Next-state, shifter, holding register and registered line value.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_DATA_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == LAST_STOP_IDX) begin
                        // Waiting byte goes straight into a new start bit.
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d     = S_START;
            shift_d     = hold_data_q;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d       = (^hold_data_q) ^ 1'(PARITY_ODD);
`endif
        end

        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = i_data;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) || hold_full_d;
    end

    // State, datapath and output registers; reset drops any partial frame
    // and the held byte and returns the line high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLK_PER_BIT=4, STOP_BITS=1, even parity
// when UART_TX_PARITY_EN is defined). A queue-based line model predicts
// o_tx/o_busy/o_data_ready every cycle; directed frames pin the model.
module tb_uart_tx;

    localparam int CPB  = 4;
    localparam int STOP = 1;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       o_data_ready;
    logic       o_tx;
    logic       o_busy;

    int tests = 0;
    int fails = 0;

    uart_tx #(
        .CLK_PER_BIT(CPB),
        .STOP_BITS  (STOP),
        .PARITY_ODD (PODD)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (i_data),
        .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready),
        .o_tx        (o_tx),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mq holds the expected line level for every remaining cycle of the
    // frame(s) already committed to the line; the holding register is
    // modelled as a full flag plus byte.
    logic       mq[$];
    bit         mfull = 1'b0;
    logic [7:0] mhold = 8'h00;
    bit         m_had;
    logic [7:0] m_hb;
    bit         m_acc;

    function automatic void push_frame(input logic [7:0] b);
        for (int c = 0; c < CPB; c++) mq.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) mq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < CPB; c++) mq.push_back((^b) ^ 1'(PODD));
`endif
        for (int c = 0; c < STOP * CPB; c++) mq.push_back(1'b1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mfull = 1'b0;
        end else begin
            m_had = mfull;
            m_hb  = mhold;
            m_acc = i_data_valid && !mfull;
            if (mq.size() != 0) void'(mq.pop_front());
            if (m_had && mq.size() == 0) begin
                push_frame(m_hb);
                mfull = 1'b0;
            end
            if (m_acc) begin
                mfull = 1'b1;
                mhold = i_data;
            end
        end
    end

    // Compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("model_tx",    o_tx,         (mq.size() != 0) ? mq[0] : 1'b1);
        chk("model_busy",  o_busy,       (mq.size() != 0) || mfull);
        chk("model_ready", o_data_ready, !mfull);
    end

    // ---------------- directed helpers ----------------
    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (o_busy && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk({name, "_idle_timeout"}, o_busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Offer up to three bytes back to back with valid held, then compare the
    // line against a hand-written bit string (bit 0 = first bit on the line).
    task automatic run_seq(input string name, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input logic [63:0] bits);
        logic [7:0] bb[3];
        int idx, pos, total;
        logic acc;
        bb[0] = b0; bb[1] = b1; bb[2] = b2;
        wait_idle(name);
        idx = 0;
        pos = -2;
        total = n * FB * CPB;
        i_data = bb[0];
        i_data_valid = 1'b1;
        for (int cyc = 0; cyc < total + 60 && pos < total; cyc++) begin
            @(negedge clk);
            if (pos == -1) chk({name, "_tx_before_start"}, o_tx, 1'b1);
            if (pos >= 0) chk({name, "_line"}, o_tx, bits[pos / CPB]);
            if (pos > -2) pos++;
            acc = i_data_valid && o_data_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (pos == -2) pos = -1;
                idx++;
                if (idx < n) i_data = bb[idx];
                else i_data_valid = 1'b0;
            end
        end
        tests++;
        if (pos != total) begin
            fails++;
            $display("FAIL %s_timeout: reached %0d of %0d line cycles", name, pos, total);
        end
        @(negedge clk);
        chk({name, "_busy_end"}, o_busy, 1'b0);
        chk({name, "_tx_end"}, o_tx, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        rst = 1'b0;
        i_data = 8'h5A;
        i_data_valid = 1'b1;
        #1 rst = 1'b1;

        // Reset held with valid asserted: no transfer.
        repeat (4) begin
            @(negedge clk);
            chk("rst_tx", o_tx, 1'b1);
            chk("rst_busy", o_busy, 1'b0);
            chk("rst_ready", o_data_ready, 1'b1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 i_data_valid = 1'b0;
        chk("post_rst_ready", o_data_ready, 1'b0);
        chk("post_rst_busy", o_busy, 1'b1);

`ifdef UART_TX_PARITY_EN
        run_seq("a5", 1, 8'hA5, 8'h00, 8'h00, 64'h54A);
        run_seq("b2b", 2, 8'h00, 8'hFF, 8'h00, 64'h2FF400);
        run_seq("three", 3, 8'h01, 8'h80, 8'h55, 64'h12AB80602);
        run_seq("par07", 1, 8'h07, 8'h00, 8'h00, 64'h60E);
`else
        run_seq("a5", 1, 8'hA5, 8'h00, 8'h00, 64'h34A);
        run_seq("b2b", 2, 8'h00, 8'hFF, 8'h00, 64'hFFA00);
        run_seq("three", 3, 8'h01, 8'h80, 8'h55, 64'h2AAC0202);
`endif

        // Reset during data bit 3 of 0x3C with a second byte waiting.
        wait_idle("rst_mid");
        i_data = 8'h3C;
        i_data_valid = 1'b1;
        @(posedge clk);
        #1 i_data = 8'h99;
        @(posedge clk);
        @(posedge clk);
        #1 i_data_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_tx", o_tx, 1'b1);
        chk("rst_mid_busy", o_busy, 1'b0);
        chk("rst_mid_ready", o_data_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
`ifdef UART_TX_PARITY_EN
        run_seq("after_rst", 1, 8'h81, 8'h00, 8'h00, 64'h502);
`else
        run_seq("after_rst", 1, 8'h81, 8'h00, 8'h00, 64'h302);
`endif

        // Randomised traffic with occasional resets; model checks every cycle.
        i_data_valid = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            acc = i_data_valid && o_data_ready && !rst;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 599) == 0);
            if (acc || !i_data_valid) begin
                i_data_valid = ($urandom_range(0, 3) == 0);
                i_data = 8'($urandom);
            end
        end
        rst = 1'b0;
        i_data_valid = 1'b0;
        repeat (FB * CPB * 2 + 4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
